// File: rtl/note_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : note_spawn_scheduler
//  Description : Queues lane spawn requests from two sources and allocates
//                the lowest free note sprite slot in the requested lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_spawn_scheduler #(
    parameter int LANES          = 5,
    parameter int SLOTS_PER_LANE = 2,
    parameter int QDEPTH         = 4,
    parameter int WAIT_MAX       = 1023
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [2:0]                        Spawn_0,
    input  logic [2:0]                        Spawn_1,
    input  logic [LANES*SLOTS_PER_LANE-1:0]   Note_Done,
    output logic [LANES*SLOTS_PER_LANE-1:0]   Note_ON,
    output logic [LANES*SLOTS_PER_LANE-1:0]   Note_Start,
    output logic                              Q_Full,
    output logic                              Overflow,
    output logic [7:0]                        Drop_Count
);

    localparam int c_NSLOTS = LANES * SLOTS_PER_LANE;
    localparam int c_PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_CW     = $clog2(QDEPTH + 1);
    localparam int c_WW     = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [2:0]      c_LANES    = 3'(LANES);
    localparam logic [c_CW-1:0] c_QDEPTH   = c_CW'(QDEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_WW-1:0] c_WAIT_MAX = c_WW'(WAIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [2:0]          r_fifo [QDEPTH];
    logic [c_PW-1:0]     r_rd;
    logic [c_PW-1:0]     r_wr;
    logic [c_CW-1:0]     r_count;
    logic [c_WW-1:0]     r_wait;
    logic [c_NSLOTS-1:0] r_note_on;
    logic [c_NSLOTS-1:0] r_note_start;
    logic                r_qfull;
    logic                r_overflow;
    logic [7:0]          r_drop_count;

    logic                w_v0;
    logic                w_v1;
    logic                w_acc0;
    logic                w_acc1;
    logic [c_CW-1:0]     w_free;
    logic [c_CW-1:0]     w_count_next;
    logic [c_PW-1:0]     w_wr_inc;
    logic [2:0]          w_head;
    logic [c_NSLOTS-1:0] w_pick;
    logic                w_found;
    logic                w_alloc;
    logic                w_claim;
    logic                w_expire;
    logic                w_pop;
    logic [1:0]          w_drops;
    logic [8:0]          w_drop_sum;
    logic [7:0]          w_drop_next;

    // Admission is judged on the registered count only, so a slot vacated by
    // this cycle's pop cannot be refilled until the next cycle.
    always_comb begin
        w_v0     = (Spawn_0 != 3'd0) && (Spawn_0 <= c_LANES);
        w_v1     = (Spawn_1 != 3'd0) && (Spawn_1 <= c_LANES);
        w_free   = c_QDEPTH - r_count;
        w_acc0   = w_v0 && (w_free != '0);
        w_acc1   = w_v1 && (w_acc0 ? (w_free > c_CNT_ONE) : (w_free != '0));
        w_wr_inc = c_PW'(w_acc0) + c_PW'(w_acc1);
    end

    // Lowest-index free slot belonging to the head request's lane.
    always_comb begin
        w_head  = r_fifo[r_rd];
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < c_NSLOTS; i++) begin
            if (!w_found && !r_note_on[i] && (3'(i / SLOTS_PER_LANE + 1) == w_head)) begin
                w_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        w_alloc      = (r_state == S_ISSUE) || (r_state == S_WAIT);
        w_claim      = w_alloc && w_found;
        w_expire     = (r_state == S_WAIT) && !w_found && (r_wait == c_WAIT_MAX);
        w_pop        = w_claim || w_expire;
        w_count_next = r_count + c_CW'(w_acc0) + c_CW'(w_acc1) - c_CW'(w_pop);
        w_drops      = 2'(w_v0 && !w_acc0) + 2'(w_v1 && !w_acc1) + 2'(w_expire);
        w_drop_sum   = {1'b0, r_drop_count} + {7'd0, w_drops};
        w_drop_next  = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_rd         <= '0;
            r_wr         <= '0;
            r_count      <= '0;
            r_wait       <= '0;
            r_note_on    <= '0;
            r_note_start <= '0;
            r_qfull      <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_fifo[i] <= 3'd0;
            end
        end else begin
            if (w_acc0) begin
                r_fifo[r_wr] <= Spawn_0;
            end
            if (w_acc1) begin
                r_fifo[w_acc0 ? r_wr + c_PW'(1) : r_wr] <= Spawn_1;
            end
            r_wr    <= r_wr + w_wr_inc;
            r_rd    <= r_rd + c_PW'(w_pop);
            r_count <= w_count_next;
            r_qfull <= (w_count_next == c_QDEPTH);

            r_note_on    <= (r_note_on & ~Note_Done) | (w_claim ? w_pick : '0);
            r_note_start <= w_claim ? w_pick : '0;
            r_overflow   <= (w_drops != 2'd0);
            r_drop_count <= w_drop_next;

            case (r_state)
                S_IDLE: begin
                    if (w_count_next != '0) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_claim) begin
                        r_state <= (w_count_next != '0) ? S_ISSUE : S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                        r_wait  <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_pop) begin
                        r_state <= (w_count_next != '0) ? S_ISSUE : S_IDLE;
                        r_wait  <= '0;
                    end else begin
                        r_wait <= r_wait + c_WW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Note_ON    = r_note_on;
    assign Note_Start = r_note_start;
    assign Q_Full     = r_qfull;
    assign Overflow   = r_overflow;
    assign Drop_Count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_note_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_spawn_scheduler
//  Description : Directed self-checking bench for note_spawn_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_note_spawn_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  spawn_0;
    logic [2:0]  spawn_1;
    logic [9:0]  note_done;
    logic [9:0]  note_on;
    logic [9:0]  note_start;
    logic        q_full;
    logic        ovf;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wait;

    note_spawn_scheduler #(
        .LANES          (5),
        .SLOTS_PER_LANE (2),
        .QDEPTH         (4),
        .WAIT_MAX       (1023)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Spawn_0    (spawn_0),
        .Spawn_1    (spawn_1),
        .Note_Done  (note_done),
        .Note_ON    (note_on),
        .Note_Start (note_start),
        .Q_Full     (q_full),
        .Overflow   (ovf),
        .Drop_Count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two requests for lane 2 occupy slots 2 and 3, leaving the FSM idle.
    task automatic fill_lane2();
        spawn_0 = 3'd2;
        spawn_1 = 3'd2;
        tick();
        spawn_0 = 3'd0;
        spawn_1 = 3'd0;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        spawn_0   = 3'd0;
        spawn_1   = 3'd0;
        note_done = 10'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_note_on",    32'(note_on),    32'h0);
        chk("reset_note_start", 32'(note_start), 32'h0);
        chk("reset_q_full",     32'(q_full),     32'h0);
        chk("reset_overflow",   32'(ovf),        32'h0);
        chk("reset_drop_count", 32'(drop_count), 32'h0);

        // T1: single request, two-edge latency
        spawn_0 = 3'd3;
        tick();
        spawn_0 = 3'd0;
        chk("t1_not_yet", 32'(note_on), 32'h000);
        tick();
        chk("t1_note_on",    32'(note_on),    32'h010);
        chk("t1_note_start", 32'(note_start), 32'h010);
        tick();
        chk("t1_start_clear", 32'(note_start), 32'h000);
        chk("t1_note_hold",   32'(note_on),    32'h010);
        note_done = 10'h010;
        tick();
        note_done = 10'h000;
        chk("t1_release", 32'(note_on), 32'h000);
        note_done = 10'h001;
        tick();
        note_done = 10'h000;
        chk("t1_done_unoccupied", 32'(note_on), 32'h000);

        // T2: two same-cycle requests for lane 1
        spawn_0 = 3'd1;
        spawn_1 = 3'd1;
        tick();
        spawn_0 = 3'd0;
        spawn_1 = 3'd0;
        tick();
        chk("t2_first_on",    32'(note_on),    32'h001);
        chk("t2_first_start", 32'(note_start), 32'h001);
        tick();
        chk("t2_second_on",    32'(note_on),    32'h003);
        chk("t2_second_start", 32'(note_start), 32'h002);
        tick();
        chk("t2_start_clear", 32'(note_start), 32'h000);
        note_done = 10'h003;
        tick();
        note_done = 10'h000;
        chk("t2_release", 32'(note_on), 32'h000);

        // T3: lane full, head times out
        fill_lane2();
        chk("t3_lane2_full", 32'(note_on), 32'h00C);
        spawn_0 = 3'd2;
        tick();
        spawn_0 = 3'd0;
        n_wait = 0;
        do begin
            tick();
            n_wait++;
        end while (!ovf && n_wait < 1100);
        chk("t3_drop_latency", 32'(n_wait),     32'd1025);
        chk("t3_overflow",     32'(ovf),        32'h1);
        chk("t3_drop_count",   32'(drop_count), 32'd1);
        chk("t3_note_on",      32'(note_on),    32'h00C);
        tick();
        chk("t3_overflow_pulse", 32'(ovf), 32'h0);

        // T4: waiting head claims a slot once it is released
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_reset_drop", 32'(drop_count), 32'd0);
        fill_lane2();
        spawn_0 = 3'd2;
        tick();
        spawn_0 = 3'd0;
        for (int i = 0; i < 10; i++) tick();
        note_done = 10'h008;
        tick();
        note_done = 10'h000;
        chk("t4_released",   32'(note_on),    32'h004);
        chk("t4_no_start",   32'(note_start), 32'h000);
        tick();
        chk("t4_reclaim_on",    32'(note_on),    32'h00C);
        chk("t4_reclaim_start", 32'(note_start), 32'h008);
        chk("t4_drop_count",    32'(drop_count), 32'd0);

        // T5: stalled head, FIFO fills and overflows
        spawn_0 = 3'd2;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_q_full",      32'(q_full),     32'h1);
        chk("t5_no_drop_yet", 32'(drop_count), 32'd0);
        tick();
        chk("t5_drop_one",    32'(drop_count), 32'd1);
        chk("t5_overflow",    32'(ovf),        32'h1);
        spawn_1 = 3'd4;
        tick();
        spawn_0 = 3'd0;
        spawn_1 = 3'd0;
        chk("t5_drop_two",    32'(drop_count), 32'd3);
        tick();
        chk("t5_ovf_clear",   32'(ovf),        32'h0);
        chk("t5_still_full",  32'(q_full),     32'h1);

        // T6: reset mid-operation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_note_on",    32'(note_on),    32'h000);
        chk("t6_q_full",     32'(q_full),     32'h0);
        chk("t6_drop_count", 32'(drop_count), 32'd0);
        chk("t6_note_start", 32'(note_start), 32'h000);
        chk("t6_overflow",   32'(ovf),        32'h0);
        tick();
        chk("t6_queue_gone", 32'(note_on),    32'h000);

        // Saturation: 300 drops on a stalled, full FIFO
        fill_lane2();
        spawn_0 = 3'd2;
        spawn_1 = 3'd2;
        tick();
        tick();
        chk("sat_full_no_drop", 32'(drop_count), 32'd0);
        for (int i = 0; i < 127; i++) tick();
        chk("sat_254", 32'(drop_count), 32'd254);
        tick();
        chk("sat_255", 32'(drop_count), 32'd255);
        for (int i = 0; i < 22; i++) tick();
        spawn_0 = 3'd0;
        spawn_1 = 3'd0;
        chk("sat_hold",     32'(drop_count), 32'd255);
        chk("sat_note_on",  32'(note_on),    32'h00C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
